// File: rtl/axi4_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register file.
// The optional AXI4L_REGS_SLVERR_EN macro makes out-of-range accesses answer SLVERR.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    WR_IDLE   = 3'd0,
    WR_W_DATA = 3'd1,
    WR_W_ADDR = 3'd2,
    WR_COMMIT = 3'd3,
    WR_RESP   = 3'd4
  } wr_state_t;

`ifdef AXI4L_REGS_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  // Response for an access: only out-of-range hits report an error, and only when enabled.
  function automatic resp_t range_resp(input logic in_range);
    range_resp = (in_range || !SLVERR_EN) ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi4_lite_regs_wr.sv
// Write channel of the AXI4-Lite register file: AW/W/B handshakes and the
// address/data latches. Emits a one-cycle commit with index, data and strobes;
// storage itself lives in the top. Response code depends on AXI4L_REGS_SLVERR_EN.
module axi4_lite_regs_wr
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_N  = 16,
  localparam int STRB_W = DATA_W / 8,
  localparam int LSB    = $clog2(STRB_W),
  localparam int IDX_W  = ADDR_W - LSB
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  output logic              commit_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic [DATA_W-1:0] data_o,
  output logic [STRB_W-1:0] strb_o,
  output logic              in_range_o
);

  localparam logic [IDX_W-1:0] REG_N_L = IDX_W'(REG_N);

  wr_state_t         state_r;
  logic              awready_r;
  logic              wready_r;
  logic              bvalid_r;
  resp_t             bresp_r;
  logic              commit_r;
  logic [IDX_W-1:0]  idx_r;
  logic [DATA_W-1:0] data_r;
  logic [STRB_W-1:0] strb_r;

  logic aw_hs_s;
  logic w_hs_s;
  logic in_range_s;
  logic unused_s;

  assign aw_hs_s    = AWVALID && awready_r;
  assign w_hs_s     = WVALID && wready_r;
  // Compare on the full index width so large addresses never alias onto real registers.
  assign in_range_s = (idx_r < REG_N_L);
  assign unused_s   = ^AWADDR[LSB-1:0];

  // Write FSM: collects AW and W in either order, commits for one cycle, then holds B.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r   <= WR_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
      commit_r  <= 1'b0;
      idx_r     <= '0;
      data_r    <= '0;
      strb_r    <= '0;
    end else begin
      commit_r <= 1'b0;
      case (state_r)
        WR_IDLE: begin
          if (aw_hs_s) begin
            idx_r <= AWADDR[ADDR_W-1:LSB];
          end
          if (w_hs_s) begin
            data_r <= WDATA;
            strb_r <= WSTRB;
          end
          if (aw_hs_s && w_hs_s) begin
            state_r   <= WR_COMMIT;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            commit_r  <= 1'b1;
          end else if (aw_hs_s) begin
            state_r   <= WR_W_DATA;
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
          end else if (w_hs_s) begin
            state_r   <= WR_W_ADDR;
            awready_r <= 1'b1;
            wready_r  <= 1'b0;
          end else begin
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
          end
        end
        WR_W_DATA: begin
          if (w_hs_s) begin
            data_r   <= WDATA;
            strb_r   <= WSTRB;
            state_r  <= WR_COMMIT;
            wready_r <= 1'b0;
            commit_r <= 1'b1;
          end else begin
            state_r <= WR_W_DATA;
          end
        end
        WR_W_ADDR: begin
          if (aw_hs_s) begin
            idx_r     <= AWADDR[ADDR_W-1:LSB];
            state_r   <= WR_COMMIT;
            awready_r <= 1'b0;
            commit_r  <= 1'b1;
          end else begin
            state_r <= WR_W_ADDR;
          end
        end
        WR_COMMIT: begin
          state_r  <= WR_RESP;
          bvalid_r <= 1'b1;
          bresp_r  <= range_resp(in_range_s);
        end
        WR_RESP: begin
          if (BREADY) begin
            state_r   <= WR_IDLE;
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
          end else begin
            state_r <= WR_RESP;
          end
        end
        default: begin
          state_r   <= WR_IDLE;
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign AWREADY    = awready_r;
  assign WREADY     = wready_r;
  assign BVALID     = bvalid_r;
  assign BRESP      = bresp_r;
  assign commit_o   = commit_r;
  assign idx_o      = idx_r;
  assign data_o     = data_r;
  assign strb_o     = strb_r;
  assign in_range_o = in_range_s;

endmodule

// File: rtl/axi4_lite_regs.sv
// AXI4-Lite slave control/status register file: REG_N registers of DATA_W bits,
// exported flat on regs_o with a one-cycle write strobe per register.
// Define AXI4L_REGS_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi4_lite_regs
  import axi4_lite_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 32,
  parameter int                REG_N   = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [ADDR_W-1:0]       AWADDR,
  input  logic [2:0]              AWPROT,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic [DATA_W-1:0]       WDATA,
  input  logic [DATA_W/8-1:0]     WSTRB,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic [1:0]              BRESP,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic [ADDR_W-1:0]       ARADDR,
  input  logic [2:0]              ARPROT,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [DATA_W-1:0]       RDATA,
  output logic [1:0]              RRESP,
  output logic [REG_N*DATA_W-1:0] regs_o,
  output logic [REG_N-1:0]        wr_stb_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - LSB;
  localparam int RIDX_W = (REG_N > 1) ? $clog2(REG_N) : 1;
  localparam logic [IDX_W-1:0] REG_N_L = IDX_W'(REG_N);

  logic [DATA_W-1:0] regs_r [REG_N];
  logic [REG_N-1:0]  wr_stb_r;
  logic              arready_r;
  logic              rvalid_r;
  logic [DATA_W-1:0] rdata_r;
  resp_t             rresp_r;

  logic              wr_commit_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [DATA_W-1:0] wr_data_s;
  logic [STRB_W-1:0] wr_strb_s;
  logic              wr_in_range_s;
  logic [RIDX_W-1:0] wr_widx_s;

  logic              ar_hs_s;
  logic [IDX_W-1:0]  ar_idx_s;
  logic              ar_in_range_s;
  logic [RIDX_W-1:0] ar_widx_s;
  logic              unused_s;

  axi4_lite_regs_wr #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_wr (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .AWVALID    (AWVALID),
    .AWREADY    (AWREADY),
    .AWADDR     (AWADDR),
    .WVALID     (WVALID),
    .WREADY     (WREADY),
    .WDATA      (WDATA),
    .WSTRB      (WSTRB),
    .BVALID     (BVALID),
    .BREADY     (BREADY),
    .BRESP      (BRESP),
    .commit_o   (wr_commit_s),
    .idx_o      (wr_idx_s),
    .data_o     (wr_data_s),
    .strb_o     (wr_strb_s),
    .in_range_o (wr_in_range_s)
  );

  assign wr_widx_s     = wr_idx_s[RIDX_W-1:0];
  assign ar_hs_s       = ARVALID && arready_r;
  assign ar_idx_s      = ARADDR[ADDR_W-1:LSB];
  assign ar_in_range_s = (ar_idx_s < REG_N_L);
  assign ar_widx_s     = ar_idx_s[RIDX_W-1:0];
  assign unused_s      = ^{AWPROT, ARPROT, ARADDR[LSB-1:0]};

  // Register storage: byte-lane merge on commit, strobe the written register next cycle.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int k = 0; k < REG_N; k++) begin
        regs_r[k] <= RST_VAL;
      end
      wr_stb_r <= '0;
    end else begin
      wr_stb_r <= '0;
      if (wr_commit_s && wr_in_range_s) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_strb_s[b]) begin
            regs_r[wr_widx_s][b*8 +: 8] <= wr_data_s[b*8 +: 8];
          end
        end
        wr_stb_r[wr_widx_s] <= 1'b1;
      end
    end
  end

  // Read channel: one outstanding beat; the captured value predates any same-edge commit.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= '0;
      rresp_r   <= RESP_OKAY;
    end else if (ar_hs_s) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b1;
      rdata_r   <= ar_in_range_s ? regs_r[ar_widx_s] : {DATA_W{1'b0}};
      rresp_r   <= range_resp(ar_in_range_s);
    end else if (rvalid_r && RREADY) begin
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
    end else begin
      arready_r <= !rvalid_r;
    end
  end

  for (genvar g = 0; g < REG_N; g++) begin : g_export
    assign regs_o[g*DATA_W +: DATA_W] = regs_r[g];
  end

  assign wr_stb_o = wr_stb_r;
  assign ARREADY  = arready_r;
  assign RVALID   = rvalid_r;
  assign RDATA    = rdata_r;
  assign RRESP    = rresp_r;

endmodule

// File: tb/tb_axi4_lite_regs.sv
// Self-checking bench for axi4_lite_regs (default 32-bit, 16 registers).
// Expected responses are queued when a transaction is issued and popped on B/R.
module tb_axi4_lite_regs;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int REG_N  = 16;
  localparam int LIMIT  = 20;

`ifdef AXI4L_REGS_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic                    ACLK = 1'b0;
  logic                    ARESETn = 1'b0;
  logic                    AWVALID = 1'b0;
  logic                    AWREADY;
  logic [ADDR_W-1:0]       AWADDR = '0;
  logic [2:0]              AWPROT = 3'd0;
  logic                    WVALID = 1'b0;
  logic                    WREADY;
  logic [DATA_W-1:0]       WDATA = '0;
  logic [3:0]              WSTRB = 4'h0;
  logic                    BVALID;
  logic                    BREADY = 1'b0;
  logic [1:0]              BRESP;
  logic                    ARVALID = 1'b0;
  logic                    ARREADY;
  logic [ADDR_W-1:0]       ARADDR = '0;
  logic [2:0]              ARPROT = 3'd0;
  logic                    RVALID;
  logic                    RREADY = 1'b0;
  logic [DATA_W-1:0]       RDATA;
  logic [1:0]              RRESP;
  logic [REG_N*DATA_W-1:0] regs_o;
  logic [REG_N-1:0]        wr_stb_o;

  exp_t        sb_q[$];
  logic [31:0] model [REG_N];
  int          tests = 0;
  int          fails = 0;

  always #5 ACLK = ~ACLK;

  axi4_lite_regs #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_N(REG_N)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .regs_o(regs_o), .wr_stb_o(wr_stb_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [REG_N*DATA_W-1:0] model_flat();
    logic [REG_N*DATA_W-1:0] v;
    for (int k = 0; k < REG_N; k++) v[k*DATA_W +: DATA_W] = model[k];
    return v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < REG_N; k++) model[k] = 32'h0;
  endfunction

  // Applies a write to the model; returns the strobe vector the DUT should pulse.
  function automatic logic [REG_N-1:0] model_write(input logic [31:0] addr,
                                                   input logic [31:0] data,
                                                   input logic [3:0] strb);
    logic [29:0] idx;
    logic [REG_N-1:0] stb;
    idx = addr[31:2];
    stb = '0;
    if (idx < 30'(REG_N)) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      stb[idx[3:0]] = 1'b1;
    end
    return stb;
  endfunction

  task automatic push_exp(input logic is_rd, input logic [31:0] addr);
    exp_t e;
    logic [29:0] idx;
    idx = addr[31:2];
    e.is_rd = is_rd;
    e.data  = (idx < 30'(REG_N)) ? model[idx[3:0]] : 32'h0;
    e.resp  = (idx < 30'(REG_N)) ? 2'b00 : OOR_RESP;
    sb_q.push_back(e);
  endtask

  task automatic drive_aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    @(negedge ACLK);
    AWVALID = 1'b1; AWADDR = addr; WVALID = 1'b1; WDATA = data; WSTRB = strb;
    while (!(AWREADY && WREADY) && n < LIMIT) begin n++; @(negedge ACLK); end
    if (n >= LIMIT) begin
      tests++; fails++;
      $display("FAIL aw_w_timeout: ready never seen for addr %h", addr);
    end
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
  endtask

  // Waits for BVALID (counting negedges), checks response against the queue and the strobe.
  task automatic collect_b(input logic [REG_N-1:0] exp_stb, output int lat);
    exp_t e;
    lat = 1;
    @(negedge ACLK);
    while (!BVALID && lat < LIMIT) begin lat++; @(negedge ACLK); end
    e = sb_q.pop_front();
    tests++;
    if (!BVALID) begin
      fails++; $display("FAIL b_timeout: BVALID=%b want 1", BVALID);
    end else if (BRESP !== e.resp || e.is_rd) begin
      fails++; $display("FAIL bresp: got %b want %b", BRESP, e.resp);
    end
    tests++;
    if (wr_stb_o !== exp_stb) begin
      fails++; $display("FAIL wr_stb: got %h want %h", wr_stb_o, exp_stb);
    end
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    @(negedge ACLK);
    tests++;
    if (wr_stb_o !== '0 || BVALID !== 1'b0) begin
      fails++; $display("FAIL stb_clear: stb=%h bvalid=%b want 0/0", wr_stb_o, BVALID);
    end
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [REG_N-1:0] stb;
    int lat;
    push_exp(1'b0, addr);
    stb = model_write(addr, data, strb);
    drive_aw_w(addr, data, strb);
    collect_b(stb, lat);
  endtask

  task automatic collect_r(input string name);
    exp_t e;
    int n = 0;
    @(negedge ACLK);
    while (!RVALID && n < LIMIT) begin n++; @(negedge ACLK); end
    e = sb_q.pop_front();
    tests++;
    if (!RVALID || !e.is_rd || RDATA !== e.data || RRESP !== e.resp) begin
      fails++;
      $display("FAIL %s: rvalid=%b rdata=%h rresp=%b want 1 %h %b", name, RVALID, RDATA, RRESP, e.data, e.resp);
    end
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
  endtask

  task automatic read_txn(input logic [31:0] addr, input string name);
    int n = 0;
    push_exp(1'b1, addr);
    @(negedge ACLK);
    ARVALID = 1'b1; ARADDR = addr;
    while (!ARREADY && n < LIMIT) begin n++; @(negedge ACLK); end
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    collect_r(name);
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    model_reset();
    repeat (5) @(negedge ACLK);
    tests++;
    if (AWREADY !== 1'b0 || WREADY !== 1'b0 || ARREADY !== 1'b0 || BVALID !== 1'b0 || RVALID !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: aw=%b w=%b ar=%b b=%b r=%b want all 0", AWREADY, WREADY, ARREADY, BVALID, RVALID);
    end
    tests++;
    if (regs_o !== model_flat() || wr_stb_o !== '0 || RDATA !== '0 || BRESP !== 2'b00 || RRESP !== 2'b00) begin
      fails++; $display("FAIL reset_data: regs=%h stb=%h rdata=%h want zeros", regs_o, wr_stb_o, RDATA);
    end
    ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);
    tests++;
    if (AWREADY !== 1'b1 || WREADY !== 1'b1 || ARREADY !== 1'b1) begin
      fails++; $display("FAIL reset_ready: aw=%b w=%b ar=%b want 1 1 1", AWREADY, WREADY, ARREADY);
    end
  endtask

  task automatic test_write_read();
    write_txn(32'h08, 32'hDEADBEEF, 4'hF);
    read_txn(32'h08, "rd_0x08");
    write_txn(32'h00, 32'h12345678, 4'hF);
    write_txn(32'h3C, 32'hA5A5_0F0F, 4'hF);
    read_txn(32'h3C, "rd_last_reg");
    read_txn(32'h0B, "rd_unaligned");
    write_txn(32'h00, 32'hFFFF_FFFF, 4'h0);
    read_txn(32'h00, "rd_strb_zero");
    tests++;
    if (regs_o !== model_flat()) begin
      fails++; $display("FAIL regs_export: got %h want %h", regs_o, model_flat());
    end
  endtask

  task automatic test_w_before_aw();
    logic [REG_N-1:0] stb;
    int n = 0;
    int lat;
    write_txn(32'h0C, 32'hFFFF_FF00, 4'hF);
    push_exp(1'b0, 32'h0C);
    stb = model_write(32'h0C, 32'h0000_0000, 4'b0101);
    @(negedge ACLK);
    WVALID = 1'b1; WDATA = 32'h0000_0000; WSTRB = 4'b0101;
    while (!WREADY && n < LIMIT) begin n++; @(negedge ACLK); end
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    @(negedge ACLK);
    tests++;
    if (AWREADY !== 1'b1 || WREADY !== 1'b0 || BVALID !== 1'b0) begin
      fails++; $display("FAIL w_addr_state: aw=%b w=%b b=%b want 1 0 0", AWREADY, WREADY, BVALID);
    end
    @(negedge ACLK);
    AWVALID = 1'b1; AWADDR = 32'h0C;
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    collect_b(stb, lat);
    tests++;
    if (lat !== 2) begin
      fails++; $display("FAIL b_latency: got %0d cycles want 2", lat);
    end
    read_txn(32'h0C, "rd_strb_merge");
    tests++;
    if (model[3] !== 32'hFF00_FF00 || regs_o[3*32 +: 32] !== 32'hFF00_FF00) begin
      fails++; $display("FAIL strb_merge: got %h want %h", regs_o[3*32 +: 32], 32'hFF00_FF00);
    end
  endtask

  task automatic test_bresp_hold();
    logic [REG_N-1:0] stb;
    int lat;
    int bad = 0;
    push_exp(1'b0, 32'h10);
    stb = model_write(32'h10, 32'h0BAD_CAFE, 4'hF);
    drive_aw_w(32'h10, 32'h0BAD_CAFE, 4'hF);
    repeat (3) @(negedge ACLK);
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      tests++;
      if (BVALID !== 1'b1 || BRESP !== 2'b00 || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
        fails++; bad++;
        $display("FAIL b_hold[%0d]: b=%b resp=%b aw=%b w=%b want 1 00 0 0", i, BVALID, BRESP, AWREADY, WREADY);
      end
    end
    collect_b('0, lat);
    tests++;
    if (lat !== 1) begin
      fails++; $display("FAIL b_hold_ready: BVALID lost, waited %0d want 1", lat);
    end
    read_txn(32'h10, "rd_after_hold");
  endtask

  task automatic test_out_of_range();
    read_txn(32'h40, "rd_oor_0x40");
    write_txn(32'h40, 32'h1111_1111, 4'hF);
    write_txn(32'h44, 32'h2222_2222, 4'hF);
    tests++;
    if (regs_o !== model_flat()) begin
      fails++; $display("FAIL oor_no_effect: got %h want %h", regs_o, model_flat());
    end
    read_txn(32'h04, "rd_no_wrap");
    read_txn(32'h8000_0008, "rd_oor_high");
  endtask

  task automatic test_read_during_commit();
    write_txn(32'h14, 32'h0000_0055, 4'hF);
    push_exp(1'b0, 32'h14);
    push_exp(1'b1, 32'h14);
    drive_aw_w(32'h14, 32'h0000_00AA, 4'hF);
    ARVALID = 1'b1; ARADDR = 32'h14;
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    begin
      exp_t eb;
      eb = sb_q.pop_front();
      sb_q.push_back(eb);
    end
    collect_r("rd_pre_write");
    begin
      logic [REG_N-1:0] stb;
      int lat;
      stb = model_write(32'h14, 32'h0000_00AA, 4'hF);
      tests++;
      if (BVALID !== 1'b1 || BRESP !== 2'b00 || regs_o !== model_flat()) begin
        fails++; $display("FAIL rw_commit: b=%b regs5=%h want 1 %h", BVALID, regs_o[5*32 +: 32], model[5]);
      end
      BREADY = 1'b1;
      @(posedge ACLK); #1;
      BREADY = 1'b0;
      void'(sb_q.pop_front());
      lat = 0;
      if (stb == '0) lat = 1;
    end
  endtask

  task automatic test_back_to_back();
    int hs = 0;
    int beats = 0;
    int a = 0;
    exp_t e;
    RREADY = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b1; ARADDR = 32'h0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge ACLK);
      if (RVALID) begin
        beats++;
        e = sb_q.pop_front();
        tests++;
        if (RDATA !== e.data || RRESP !== e.resp) begin
          fails++; $display("FAIL b2b_data[%0d]: got %h/%b want %h/%b", c, RDATA, RRESP, e.data, e.resp);
        end
      end
      if (ARREADY) begin
        hs++;
        push_exp(1'b1, ARADDR);
      end
      @(posedge ACLK); #1;
      if (ARREADY == 1'b0 && hs > a) begin
        a = hs;
        ARADDR = 32'(a * 4);
      end
    end
    ARVALID = 1'b0;
    @(negedge ACLK);
    RREADY = 1'b0;
    tests++;
    if (hs !== 4 || beats !== 4) begin
      fails++; $display("FAIL b2b_rate: hs=%0d beats=%0d want 4 4", hs, beats);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int bseen = 0;
    @(negedge ACLK);
    AWVALID = 1'b1; AWADDR = 32'h18;
    while (!AWREADY && n < LIMIT) begin n++; @(negedge ACLK); end
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    @(negedge ACLK);
    tests++;
    if (AWREADY !== 1'b0 || WREADY !== 1'b1) begin
      fails++; $display("FAIL w_data_state: aw=%b w=%b want 0 1", AWREADY, WREADY);
    end
    ARESETn = 1'b0;
    model_reset();
    sb_q.delete();
    @(negedge ACLK);
    tests++;
    if (regs_o !== model_flat() || BVALID !== 1'b0 || WREADY !== 1'b0) begin
      fails++; $display("FAIL mid_reset: regs=%h b=%b w=%b want 0 0 0", regs_o, BVALID, WREADY);
    end
    @(negedge ACLK);
    ARESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      if (BVALID) bseen++;
    end
    tests++;
    if (bseen !== 0 || AWREADY !== 1'b1 || WREADY !== 1'b1) begin
      fails++; $display("FAIL mid_reset_idle: bseen=%0d aw=%b w=%b want 0 1 1", bseen, AWREADY, WREADY);
    end
    write_txn(32'h18, 32'hC0FF_EE00, 4'hF);
    read_txn(32'h18, "rd_after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_w_before_aw();
    test_bresp_hold();
    test_out_of_range();
    test_read_during_commit();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
